// File: rtl/sme_pkg.sv
// Shared types for the SME host driver: widths, FSM states, result bundle.
// Imported by the driver top and its character buffer.
package sme_pkg;

    localparam int SME_CHAR_W = 8;
    localparam int SME_IDX_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_WAIT,
        ST_RESULT
    } drv_state_e;

    typedef struct packed {
        logic                 match;
        logic [SME_IDX_W-1:0] index;
        logic                 err;
        logic                 timeout;
    } res_t;

endpackage

// File: rtl/sme_char_buffer.sv
// Character store for one string or pattern burst plus its captured length.
// Storage is not reset; it is always written before it is replayed.
import sme_pkg::*;

module sme_char_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_wr_ptr,
    input  logic [SME_CHAR_W-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_ptr,
    output logic [SME_CHAR_W-1:0] o_rd_data,
    input  logic                  i_len_we,
    input  logic [PW-1:0]         i_len,
    output logic [PW-1:0]         o_len
);

    logic [SME_CHAR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_len;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_wr_ptr] <= i_wr_data;
        if (i_len_we)
            r_len <= i_len;
    end

    assign o_rd_data = r_mem[i_rd_ptr];
    assign o_len     = r_len;

endmodule

// File: rtl/sme_host_driver.sv
// Host-side initiator for the SME char stream: buffers a string or pattern,
// replays it as one gap-free burst and returns the SME result to the host.
import sme_pkg::*;

module sme_host_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_is_pattern,
    input  logic [SME_CHAR_W-1:0] cmd_char,
    input  logic                  cmd_last,
    output logic [SME_CHAR_W-1:0] chardata,
    output logic                  isstring,
    output logic                  ispattern,
    input  logic                  valid,
    input  logic                  match,
    input  logic [SME_IDX_W-1:0]  match_index,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_match,
    output logic [SME_IDX_W-1:0]  res_index,
    output logic                  res_err,
    output logic                  res_timeout
);

    localparam int AW = $clog2(STR_MAX);
    localparam int PW = $clog2(STR_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    drv_state_e            r_state;
    logic                  r_is_pat;
    logic                  r_str_loaded;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [TW-1:0]         r_wcnt;
    logic                  r_cmd_ready;
    logic [SME_CHAR_W-1:0] r_chardata;
    logic                  r_isstring;
    logic                  r_ispattern;
    logic                  r_res_valid;
    res_t                  r_res;

    logic                  w_acc;
    logic                  w_kind;
    logic [PW-1:0]         w_lim;
    logic                  w_we;
    logic [PW-1:0]         w_len;
    logic [PW-1:0]         w_len_q;
    logic [SME_CHAR_W-1:0] w_rd_data;
    logic [SME_CHAR_W-1:0] w_first;

    assign w_acc  = cmd_valid & r_cmd_ready;
    assign w_kind = (r_state == ST_LOAD) ? r_is_pat : cmd_is_pattern;
    assign w_lim  = w_kind ? PW'(PAT_MAX) : PW'(STR_MAX);
    // Chars beyond the length limit are accepted but never stored.
    assign w_we   = w_acc & (r_wr_ptr < w_lim);
    assign w_len  = r_wr_ptr + PW'(w_we);
    // A one-char burst is written on the same edge it is launched.
    assign w_first = (w_we && r_wr_ptr == '0) ? cmd_char : w_rd_data;

    sme_char_buffer #(
        .DEPTH(STR_MAX)
    ) u_buf (
        .clk      (clk),
        .i_we     (w_we),
        .i_wr_ptr (r_wr_ptr[AW-1:0]),
        .i_wr_data(cmd_char),
        .i_rd_ptr (r_rd_ptr[AW-1:0]),
        .o_rd_data(w_rd_data),
        .i_len_we (w_acc & cmd_last),
        .i_len    (w_len),
        .o_len    (w_len_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_is_pat     <= 1'b0;
            r_str_loaded <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wcnt       <= '0;
            r_cmd_ready  <= 1'b0;
            r_chardata   <= '0;
            r_isstring   <= 1'b0;
            r_ispattern  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res        <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    r_cmd_ready <= 1'b1;
                    if (w_acc) begin
                        r_is_pat <= w_kind;
                        r_state  <= ST_LOAD;
                        if (w_we)
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (cmd_last) begin
                            r_wr_ptr    <= '0;
                            r_cmd_ready <= 1'b0;
                            if (w_kind && !r_str_loaded) begin
                                r_state       <= ST_RESULT;
                                r_res_valid   <= 1'b1;
                                r_res.match   <= 1'b0;
                                r_res.index   <= '0;
                                r_res.err     <= 1'b1;
                                r_res.timeout <= 1'b0;
                            end else begin
                                r_state     <= w_kind ? ST_SEND_PAT : ST_SEND_STR;
                                r_chardata  <= w_first;
                                r_isstring  <= ~w_kind;
                                r_ispattern <= w_kind;
                                r_rd_ptr    <= PW'(1);
                            end
                        end
                    end
                end
                ST_SEND_STR, ST_SEND_PAT: begin
                    if (r_rd_ptr < w_len_q) begin
                        r_chardata <= w_rd_data;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                    end else begin
                        r_chardata  <= '0;
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b0;
                        r_rd_ptr    <= '0;
                        r_wcnt      <= '0;
                        if (r_state == ST_SEND_STR) begin
                            r_str_loaded <= 1'b1;
                            r_cmd_ready  <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (valid) begin
                        r_state       <= ST_RESULT;
                        r_res_valid   <= 1'b1;
                        r_res.match   <= match;
                        r_res.index   <= match_index;
                        r_res.err     <= 1'b0;
                        r_res.timeout <= 1'b0;
                    end else if (r_wcnt == TW'(TIMEOUT)) begin
                        r_state       <= ST_RESULT;
                        r_res_valid   <= 1'b1;
                        r_res.match   <= 1'b0;
                        r_res.index   <= '0;
                        r_res.err     <= 1'b0;
                        r_res.timeout <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_res       <= '0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign chardata    = r_chardata;
    assign isstring    = r_isstring;
    assign ispattern   = r_ispattern;
    assign res_valid   = r_res_valid;
    assign res_match   = r_res.match;
    assign res_index   = r_res.index;
    assign res_err     = r_res.err;
    assign res_timeout = r_res.timeout;

endmodule

// File: tb/tb_sme_host_driver.sv
// Directed bench for sme_host_driver: string/pattern bursts, result handshake,
// no-string error, timeout, truncation and reset mid-burst.
module tb_sme_host_driver;

    localparam int TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_is_pattern = 1'b0;
    logic [7:0] cmd_char = 8'h00;
    logic       cmd_last = 1'b0;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid = 1'b0;
    logic       match = 1'b0;
    logic [4:0] match_index = 5'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_err;
    logic       res_timeout;

    int n_chk = 0;
    int n_err = 0;

    sme_host_driver #(
        .STR_MAX(32),
        .PAT_MAX(8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_is_pattern(cmd_is_pattern),
        .cmd_char      (cmd_char),
        .cmd_last      (cmd_last),
        .chardata      (chardata),
        .isstring      (isstring),
        .ispattern     (ispattern),
        .valid         (valid),
        .match         (match),
        .match_index   (match_index),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_match     (res_match),
        .res_index     (res_index),
        .res_err       (res_err),
        .res_timeout   (res_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns positioned in the first cycle after the edge taking cmd_last.
    task automatic send(input logic pat, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            cmd_valid      = 1'b1;
            cmd_is_pattern = pat;
            cmd_char       = base + 8'(i);
            cmd_last       = (i == n - 1);
            step();
        end
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("hs_done", {res_valid, cmd_ready}, 2'b01);
    endtask

    function automatic logic [19:0] all_out();
        return {cmd_ready, chardata, isstring, ispattern, res_valid,
                res_match, res_index, res_err, res_timeout};
    endfunction

    initial begin
        logic [19:0] snap;
        int          n;

        // 1: reset
        repeat (3) begin
            step();
            chk("rst_outs", 32'(all_out()), 32'h0);
        end
        reset = 1'b0;
        step();
        chk("rdy_after_rst", 32'(cmd_ready), 32'h1);

        // 2: string "abcd"
        send(1'b0, 4, 8'h61);
        for (int k = 0; k < 4; k++) begin
            chk("str_beat", {isstring, ispattern, chardata},
                {1'b1, 1'b0, 8'h61 + 8'(k)});
            step();
        end
        chk("str_end", {isstring, ispattern, chardata, res_valid, cmd_ready},
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b1});

        // 3: pattern "bc", SME answers 3 cycles after the burst
        send(1'b1, 2, 8'h62);
        for (int k = 0; k < 2; k++) begin
            chk("pat_beat", {isstring, ispattern, chardata},
                {1'b0, 1'b1, 8'h62 + 8'(k)});
            step();
        end
        chk("pat_end", {ispattern, chardata}, 9'h0);
        step();
        step();
        valid       = 1'b1;
        match       = 1'b1;
        match_index = 5'd1;
        step();
        valid       = 1'b0;
        match       = 1'b0;
        match_index = 5'd0;
        chk("pat_res", {res_valid, res_match, res_index, res_err,
                        res_timeout, cmd_ready},
            {1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0});
        snap = all_out();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("res_hold", 32'(all_out()), 32'(snap));
        end
        handshake();

        // 4: pattern with no string loaded
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        send(1'b1, 1, 8'h78);
        chk("err_res", {ispattern, res_valid, res_err, res_match, res_index},
            {1'b0, 1'b1, 1'b1, 1'b0, 5'd0});
        handshake();

        // 5: SME silent -> timeout
        send(1'b0, 2, 8'h41);
        step();
        step();
        send(1'b1, 1, 8'h41);
        chk("to_beat", {ispattern, chardata}, {1'b1, 8'h41});
        n = 0;
        while (!res_valid && n < TIMEOUT + 100) begin
            step();
            n++;
        end
        chk("to_lat", 32'(n >= TIMEOUT && n <= TIMEOUT + 2), 32'h1);
        chk("to_res", {res_valid, res_timeout, res_match, res_err, res_index},
            {1'b1, 1'b1, 1'b0, 1'b0, 5'd0});
        handshake();

        // 6: 40 string chars truncated to 32
        send(1'b0, 40, 8'h00);
        for (int k = 0; k < 32; k++) begin
            chk("trunc_beat", {isstring, chardata}, {1'b1, 8'(k)});
            step();
        end
        chk("trunc_end", {isstring, chardata}, 9'h0);

        // 6b: reset during the replay
        send(1'b0, 40, 8'h00);
        for (int k = 0; k < 9; k++) begin
            chk("rb_beat", {isstring, chardata}, {1'b1, 8'(k)});
            step();
        end
        reset = 1'b1;
        step();
        chk("rb_drop", {isstring, ispattern, chardata}, 10'h0);
        reset = 1'b0;
        step();
        send(1'b1, 1, 8'h62);
        chk("rb_err", {ispattern, res_valid, res_err}, {1'b0, 1'b1, 1'b1});
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    always @(negedge clk) begin
        if (isstring && ispattern) begin
            n_err++;
            $display("FAIL both_strobes got=1 exp=0");
        end
    end

endmodule
